md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The module SHALL use a single clock; reset SHALL be synchronous and active-low.
REQ-002 The port clk SHALL be an input, 1 bit wide: the clock; all state updates on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: synchronous active-low reset.
REQ-004 The port start SHALL be an input, 1 bit wide: request to begin a multiply or divide with MDop, A and B.
REQ-005 The port MDop SHALL be an input, 2 bits wide: operation select; 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-006 The ports A and B SHALL be inputs, 32 bits wide each: A is rs (multiplicand or dividend) and B is rt (multiplier or divisor).
REQ-007 The ports hi_we and lo_we SHALL be inputs, 1 bit wide each: direct writes to HI and LO (MTHI, MTLO).
REQ-008 The port wd SHALL be an input, 32 bits wide: write data for hi_we and lo_we.
REQ-009 The ports hi and lo SHALL be outputs, 32 bits wide each: the registered HI and LO values (MFHI, MFLO).
REQ-010 The port busy SHALL be an output, 1 bit wide: an operation is in progress and the controller stalls.
REQ-011 The port done SHALL be an output, 1 bit wide: a one-cycle pulse when HI and LO take a new result.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and FIN.
REQ-013 From IDLE, start=1 SHALL move the FSM to CALC, latch MDop, A and B, and load cnt=0.
REQ-014 In CALC, the FSM SHALL run one iteration per cycle; after 32 iterations (cnt==31) it SHALL move to FIN.
REQ-015 FIN SHALL last one cycle: apply the sign correction, write HI and LO at the end of the cycle, then return to IDLE.
REQ-016 Timing: if start is sampled at edge 0, busy SHALL be 1 in cycles 1-33, HI and LO SHALL be updated at edge 33, and in cycle 34 done=1 and busy=0.
REQ-017 busy SHALL equal (state != IDLE), and SHALL be registered.
REQ-018 done SHALL be 1 for exactly one cycle per completed operation.
REQ-019 MULTU and DIVU SHALL treat A and B as unsigned.
REQ-020 MULT and DIV SHALL take the magnitudes of A and B, and FIN SHALL negate the results.
  - MULT: negate the 64-bit product when sign(A) XOR sign(B).
  - DIV: negate LO when sign(A) XOR sign(B); HI SHALL take the sign of A.
REQ-021 Multiply SHALL be a radix-2 shift-add producing a 64-bit product: HI = product[63:32], LO = product[31:0].
REQ-022 Divide SHALL be restoring division: LO = quotient, HI = remainder; the remainder magnitude SHALL be less than |B|.
REQ-023 Divide by zero (B==0, DIV or DIVU) SHALL complete with the normal latency and set LO=32'hFFFFFFFF, HI=A.
REQ-024 DIV with A=32'h80000000 and B=32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0.
REQ-025 start SHALL be ignored while busy=1; the operation in progress and its latched operands SHALL be unaffected.
REQ-026 In IDLE, hi_we SHALL set HI=wd and lo_we SHALL set LO=wd at the edge; both may be asserted in the same cycle.
REQ-027 While busy=1, hi_we and lo_we SHALL be ignored.
REQ-028 If start and hi_we or lo_we are asserted together in IDLE, the write SHALL take effect and the operation SHALL also start; the result later overwrites both HI and LO.
REQ-029 HI and LO SHALL change only on a FIN completion, a permitted write, or reset.
REQ-030 Outputs hi and lo SHALL be the registers directly, with no combinational path from the inputs.

Reset
REQ-031 With rst_n=0 at a clock edge, the block SHALL set state=IDLE, cnt=0, hi=0, lo=0, busy=0 and done=0.
REQ-032 Reset during CALC or FIN SHALL abandon the operation: HI and LO SHALL stay 0 and done SHALL NOT pulse.
REQ-033 Reset SHALL take priority over start, hi_we and lo_we.

Verification
REQ-034 The bench SHALL cover signed multiply: MULT, A=32'hFFFFFFFD (-3), B=5 -> done in cycle 34, HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
REQ-035 The bench SHALL cover unsigned multiply: MULTU, A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-036 The bench SHALL cover signed divide: DIV, A=32'hFFFFFFF9 (-7), B=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
  - DIVU, A=100, B=0 -> LO=32'hFFFFFFFF, HI=100.
REQ-037 The bench SHALL cover start while busy: DIVU 100/7 started, then in cycle 10 start a MULT 2*3 with hi_we=1, wd=5.
  - Required: LO=14, HI=2, a single done pulse, and the HI write ignored.
REQ-038 The bench SHALL cover reset mid-operation: MULTU started, rst_n=0 in cycle 20 -> next cycle busy=0 and hi=lo=0, with no done afterwards.
  - Then in IDLE, hi_we=1 and lo_we=1 with wd=32'hA5A5A5A5 -> both registers read 32'hA5A5A5A5.

Source files
------------

// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Iterative 32-bit multiply/divide unit with HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [4:0] c_LAST_ITER = 5'd31;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg;
  logic        r_sign_a;
  logic        r_bzero;
  logic [31:0] r_bmag;
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic        w_div_ok;
  logic [31:0] w_div_rem;
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == c_LAST_ITER) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // MULT and DIV (even opcodes) iterate on operand magnitudes
  assign w_signed = ~MDop[0];
  assign w_a_mag  = (w_signed && A[31]) ? -A : A;
  assign w_b_mag  = (w_signed && B[31]) ? -B : B;

  // Shift-add: {acc_hi, acc_lo} holds partial product / remaining multiplier
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_bmag} : 33'd0);

  // Restoring divide: acc_hi is the remainder, acc_lo shifts dividend out and quotient in
  assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_bmag});
  assign w_div_rem   = w_div_shift[31:0] - r_bmag;

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  // A zero divisor leaves |A| as remainder, so sign-correcting it restores A
  assign w_quo_fix  = r_bzero ? 32'hFFFF_FFFF : (r_neg ? -r_acc_lo : r_acc_lo);
  assign w_rem_fix  = r_sign_a ? -r_acc_hi : r_acc_hi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_sign_a <= 1'b0;
      r_bzero  <= 1'b0;
      r_bmag   <= 32'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wd;
          if (lo_we) r_lo <= wd;
          if (start) begin
            r_cnt    <= 5'd0;
            r_is_div <= MDop[1];
            r_neg    <= w_signed & (A[31] ^ B[31]);
            r_sign_a <= w_signed & A[31];
            r_bzero  <= (B == 32'd0);
            r_bmag   <= w_b_mag;
            r_acc_hi <= 32'd0;
            r_acc_lo <= w_a_mag;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_is_div) begin
            r_acc_hi <= w_div_ok ? w_div_rem : w_div_shift[31:0];
            r_acc_lo <= {r_acc_lo[30:0], w_div_ok};
          end else begin
            r_acc_hi <= w_mul_sum[32:1];
            r_acc_lo <= {w_mul_sum[0], r_acc_lo[31:1]};
          end
        end
        S_FIN: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[63:32];
            r_lo <= w_prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module      : tb_md_unit
// Description : Directed self-checking bench for md_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  MDop;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  md_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .MDop  (MDop),
    .A     (A),
    .B     (B),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Launch an operation at edge 0 and wait for done; lat is the cycle done is seen in
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic hw, input logic lw, input logic [31:0] wdat,
                        output int lat, output logic b1, output logic b33);
    @(negedge clk);
    MDop = op; A = a; B = b; start = 1'b1;
    hi_we = hw; lo_we = lw; wd = wdat;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    lat = 1;
    b1  = busy;
    b33 = 1'b0;
    if (hw) chk("idle_hi_write_with_start", {32'd0, hi}, {32'd0, wdat});
    if (lw) chk("idle_lo_write_with_start", {32'd0, lo}, {32'd0, wdat});
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 33) b33 = busy;
    end
  endtask

  task automatic op_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int   lat;
    logic b1, b33;
    run_op(op, a, b, 1'b0, 1'b0, 32'd0, lat, b1, b33);
    chk({tag, "_lat"}, 64'(lat), 64'd34);
    chk({tag, "_busy_c1"}, {63'd0, b1}, 64'd1);
    chk({tag, "_busy_c33"}, {63'd0, b33}, 64'd1);
    chk({tag, "_busy_c34"}, {63'd0, busy}, 64'd0);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    @(posedge clk);
    #1;
    chk({tag, "_done_once"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int   cyc;
    int   ndone;
    int   dcyc;
    int   lat;
    logic b1, b33;
    logic [31:0] prev_hi;

    rst_n = 1'b0; start = 1'b0; MDop = 2'd0; A = 32'd0; B = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wd = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;

    op_check("mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    op_check("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    op_check("div_neg7by2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op_check("divu_by0", 2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    op_check("div_by0_neg", 2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    op_check("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    op_check("mult_neg_neg", 2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6);

    // Direct writes in IDLE
    @(negedge clk);
    hi_we = 1'b1; wd = 32'h1111_2222;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    chk("mthi_hi", {32'd0, hi}, 64'h1111_2222);
    chk("mthi_lo_kept", {32'd0, lo}, 64'd6);

    // Start while busy must be ignored, along with the HI write
    prev_hi = 32'h1111_2222;
    ndone = 0; dcyc = 0;
    @(negedge clk);
    MDop = 2'd3; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    repeat (45) begin
      if (cyc == 10) begin
        start = 1'b1; MDop = 2'd0; A = 32'd2; B = 32'd3; hi_we = 1'b1; wd = 32'd5;
      end
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0; hi_we = 1'b0;
      if (done) begin
        ndone++;
        dcyc = cyc;
      end
      if (cyc == 11) chk("busy_hi_write_ignored", {32'd0, hi}, {32'd0, prev_hi});
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);
    chk("busy_start_dcyc", 64'(dcyc), 64'd34);
    chk("busy_start_hi", {32'd0, hi}, 64'd2);
    chk("busy_start_lo", {32'd0, lo}, 64'd14);

    // Write and start together in IDLE: write lands, result later overwrites it
    run_op(2'd1, 32'd6, 32'd7, 1'b1, 1'b1, 32'h0000_1234, lat, b1, b33);
    chk("wr_start_lat", 64'(lat), 64'd34);
    chk("wr_start_hi", {32'd0, hi}, 64'd0);
    chk("wr_start_lo", {32'd0, lo}, 64'd42);

    // Reset in the middle of CALC
    @(negedge clk);
    MDop = 2'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    chk("midrst_hi_after", {32'd0, hi}, 64'd0);

    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both_hi", {32'd0, hi}, 64'hA5A5_A5A5);
    chk("mt_both_lo", {32'd0, lo}, 64'hA5A5_A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
